// File: rtl/sar_search.sv
// sar_search: successive-approximation controller. It drives a trial code into an
// external magnitude comparator and uses the comparator flags to settle on the
// code that matches the target, one bit per step, starting from the MSB.
module sar_search #(
    parameter int N          = 8,
    parameter int SETTLE     = 2,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic         clk,
    input  logic         reset_p,
    input  logic         start,
    input  logic         cmp_equal,
    input  logic         cmp_greater,
    input  logic         cmp_less,
    output logic [N-1:0] trial,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);

    localparam int IW = $clog2(N);
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);
    localparam logic [IW-1:0] MSB_IDX  = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  acc, acc_n;
    logic [IW-1:0] idx, idx_n;
    logic [SW-1:0] cnt, cnt_n;
    logic [N-1:0]  trial_n, result_n;
    logic          busy_n, done_n;
    logic [N-1:0]  cur;
    logic          keep;

    // Only greater/equal decide a bit; cmp_less carries no extra information.
    logic unused_flags;
    assign unused_flags = cmp_less;

    // State and datapath registers; reset abandons any search and clears the result.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            cnt    <= '0;
            trial  <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            idx    <= idx_n;
            cnt    <= cnt_n;
            trial  <= trial_n;
            result <= result_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    // Next-state and next-output logic; outputs are registered, so values set here
    // appear in the cycle that follows the deciding edge.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        idx_n    = idx;
        cnt_n    = cnt;
        trial_n  = trial;
        result_n = result;
        busy_n   = busy;
        done_n   = 1'b0;

        keep     = cmp_greater | cmp_equal;
        cur      = acc;
        cur[idx] = keep;

        unique case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    state_n          = HOLD;
                    idx_n            = MSB_IDX;
                    acc_n            = '0;
                    cnt_n            = '0;
                    trial_n          = '0;
                    trial_n[N-1]     = 1'b1;
                    busy_n           = 1'b1;
                end
            end

            HOLD: begin
                if (cnt == SETTLE_V) begin
                    acc_n = cur;
                    if (idx == '0 || (EARLY_EXIT && cmp_equal)) begin
                        // On an early exit cur equals the current trial (bit kept).
                        result_n = cur;
                        trial_n  = cur;
                        state_n  = DONE;
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                    end else begin
                        idx_n                  = idx - IW'(1);
                        trial_n                = cur;
                        trial_n[idx - IW'(1)]  = 1'b1;
                        cnt_n                  = '0;
                    end
                end else begin
                    cnt_n = cnt + SW'(1);
                end
            end

            DONE: begin
                // A start seen here is dropped; the next IDLE cycle may accept one.
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed bench for sar_search with behavioural comparators,
// a scoreboard of expected results and per-cycle trial/busy/done checks.
module tb_sar_search;

    localparam int N   = 8;
    localparam int ST  = 2;
    localparam int BIT = ST + 1;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       start0, start1;
    logic [7:0] tgt0, tgt1;
    logic [7:0] trial0, trial1, result0, result1;
    logic       busy0, busy1, done0, done1;
    logic       eq0, gt0, lt0, eq1, gt1, lt1;
    logic       g0, g1;
    logic [2:0] rnd;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    logic [7:0] lit_q[$];
    logic [7:0] last_res[2];

    always #5 clk = ~clk;

    // Behavioural comparators (A = target, B = trial); garbage replaces them when enabled.
    assign eq0 = g0 ? rnd[0] : (tgt0 == trial0);
    assign gt0 = g0 ? rnd[1] : (tgt0 >  trial0);
    assign lt0 = g0 ? rnd[2] : (tgt0 <  trial0);
    assign eq1 = g1 ? rnd[0] : (tgt1 == trial1);
    assign gt1 = g1 ? rnd[1] : (tgt1 >  trial1);
    assign lt1 = g1 ? rnd[2] : (tgt1 <  trial1);

    sar_search #(.N(N), .SETTLE(ST), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .reset_p(reset_p), .start(start0),
        .cmp_equal(eq0), .cmp_greater(gt0), .cmp_less(lt0),
        .trial(trial0), .result(result0), .busy(busy0), .done(done0)
    );

    sar_search #(.N(N), .SETTLE(ST), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .reset_p(reset_p), .start(start1),
        .cmp_equal(eq1), .cmp_greater(gt1), .cmp_less(lt1),
        .trial(trial1), .result(result1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_res(input logic [7:0] tgt, input bit ee);
        logic [7:0] acc, t;
        acc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            t = acc | (8'd1 << i);
            if (tgt >= t) acc = t;
            if (ee && tgt == t) break;
        end
        return acc;
    endfunction

    function automatic logic [7:0] tr_of(input int s);
        return (s == 0) ? trial0 : trial1;
    endfunction
    function automatic logic [7:0] res_of(input int s);
        return (s == 0) ? result0 : result1;
    endfunction
    function automatic logic busy_of(input int s);
        return (s == 0) ? busy0 : busy1;
    endfunction
    function automatic logic done_of(input int s);
        return (s == 0) ? done0 : done1;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s == 0) start0 = v; else start1 = v;
    endtask

    // One search on instance sel; expected trials from lit_q if given, else from a model.
    task automatic search(input int sel, input logic [7:0] tgt, input bit garb,
                          input bit poke, input int exp_lat);
        logic [7:0] tr[$];
        logic [7:0] acc, t, exp_r;
        int         nb;
        bit         fin;
        bit         samp;
        acc = '0;
        tr  = {};
        for (int i = N - 1; i >= 0; i--) begin
            t = acc | (8'd1 << i);
            tr.push_back(t);
            if (tgt >= t) acc = t;
            if (sel == 1 && tgt == t) break;
        end
        if (lit_q.size() > 0) tr = lit_q;
        nb = tr.size();
        sb.push_back(model_res(tgt, sel == 1));
        if (sel == 0) tgt0 = tgt; else tgt1 = tgt;
        set_start(sel, 1'b1);
        fin = 1'b0;
        for (int m = 0; m < 40 && !fin; m++) begin
            @(posedge clk); #1;
            if (m < nb * BIT) begin
                chk("trial", tr_of(sel), tr[m / BIT]);
                chk("busy_hold", busy_of(sel), 1);
                chk("done_hold", done_of(sel), 0);
                chk("result_hold", res_of(sel), last_res[sel]);
            end else begin
                exp_r = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                chk("done", done_of(sel), 1);
                chk("busy_done", busy_of(sel), 0);
                chk("result", res_of(sel), exp_r);
                chk("trial_done", tr_of(sel), exp_r);
                chk("latency", m + 1, exp_lat);
                last_res[sel] = exp_r;
                fin = 1'b1;
            end
            set_start(sel, poke && (fin || m == 3 || m == 4 || m == 5 || m == 10));
            samp = ((m + 1) % BIT == 0) && ((m + 1) <= nb * BIT);
            rnd  = 3'($urandom);
            if (sel == 0) g0 = garb && !samp; else g1 = garb && !samp;
        end
        g0 = 1'b0;
        g1 = 1'b0;
        if (!fin) begin
            chk("timeout", 0, 1);
            sb.delete();
        end
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        chk("no_restart", busy_of(sel), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk("no_extra_done", done_of(sel), 0);
            chk("idle_busy", busy_of(sel), 0);
        end
    endtask

    initial begin
        logic [7:0] tl[3];
        int         idx, prev, n, pulses;

        reset_p = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        tgt0 = '0; tgt1 = '0;
        g0 = 1'b0; g1 = 1'b0; rnd = '0;
        last_res[0] = '0; last_res[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trial", trial0, 0);
        chk("rst_result", result0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_trial1", trial1, 0);
        chk("rst_busy1", busy1, 0);
        reset_p = 1'b0;
        @(posedge clk); #1;

        // Full search on 200.
        lit_q = {8'd128, 8'd192, 8'd224, 8'd208, 8'd200, 8'd204, 8'd202, 8'd201};
        search(0, 8'd200, 1'b0, 1'b0, 25);
        // Early exit on 200.
        lit_q = {8'd128, 8'd192, 8'd224, 8'd208, 8'd200};
        search(1, 8'd200, 1'b0, 1'b0, 16);
        lit_q.delete();

        // Extremes: last HOLD trial is 1 for target 0 and 255 for target 255.
        search(0, 8'd0, 1'b0, 1'b0, 25);
        search(0, 8'd255, 1'b0, 1'b0, 25);
        search(1, 8'd0, 1'b0, 1'b0, 25);

        // Garbage flags between samples, plus start pulses while busy and in DONE.
        search(0, 8'd200, 1'b1, 1'b1, 25);
        search(0, 8'd93, 1'b1, 1'b0, 25);

        // Reset in the middle of a search.
        tgt0 = 8'd77;
        start0 = 1'b1;
        for (int m = 0; m < 10; m++) begin
            @(posedge clk); #1;
            start0 = 1'b0;
            if (m == 9) reset_p = 1'b1;
        end
        @(posedge clk); #1;
        reset_p = 1'b0;
        last_res[0] = '0;
        last_res[1] = '0;
        chk("midrst_trial", trial0, 0);
        chk("midrst_result", result0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) pulses++;
        end
        chk("midrst_nodone", pulses, 0);
        search(0, 8'd77, 1'b0, 1'b0, 25);

        // Back-to-back with start held high; target changes per search.
        tl[0] = 8'd17; tl[1] = 8'd99; tl[2] = 8'd250;
        idx = 0; prev = 0; n = 0;
        tgt0 = tl[0];
        sb.push_back(model_res(tl[0], 1'b0));
        start0 = 1'b1;
        for (int c = 0; c < 120 && idx < 3; c++) begin
            @(posedge clk); #1;
            n++;
            if (done0 === 1'b1) begin
                chk("b2b_result", result0, (sb.size() > 0) ? sb.pop_front() : 8'hxx);
                if (idx == 0) chk("b2b_first", n, 25);
                else          chk("b2b_period", n - prev, 26);
                prev = n;
                idx++;
                if (idx < 3) begin
                    tgt0 = tl[idx];
                    sb.push_back(model_res(tl[idx], 1'b0));
                end else begin
                    start0 = 1'b0;
                end
            end
        end
        start0 = 1'b0;
        chk("b2b_count", idx, 3);
        @(posedge clk); #1;
        chk("b2b_idle", busy0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
